// File: rtl/or_reduce_pipe.sv
// Pipelined WIDTH-bit reduction (OR/AND/XOR/NOR) built as a registered binary tree,
// one tree level per stage, with valid/ready backpressure and a sticky "result was 1" flag.
module or_reduce_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic [1:0]       in_op_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_bit_o,
  output logic [1:0]       out_op_o,
  input  logic             sticky_clr_i,
  output logic             sticky_o
);

  localparam int unsigned LEVELS = (WIDTH <= 1) ? 1 : $clog2(WIDTH);
  localparam int unsigned PAD    = 1 << LEVELS;

  localparam logic [1:0] OpOr  = 2'b00;
  localparam logic [1:0] OpAnd = 2'b01;
  localparam logic [1:0] OpXor = 2'b10;

  function automatic logic combine(input logic [1:0] op, input logic a, input logic b);
    case (op)
      OpAnd:   return a & b;
      OpXor:   return a ^ b;
      default: return a | b;  // OR, and the OR core of NOR
    endcase
  endfunction

  logic [LEVELS-1:0] valid_q, valid_d;
  logic [1:0]        op_q [LEVELS];
  logic [1:0]        op_d [LEVELS];
  // Heap-ordered tree nodes: node 0 is the root, node i has children 2i+1 and 2i+2.
  logic [PAD-2:0]    tree_q, tree_d;
  logic [PAD-1:0]    leaf;
  logic [1:0]        eff_op;
  logic [1:0]        root_op;
  logic              stall, accept, transfer;
  logic              sticky_q, sticky_d;

  assign out_valid_o = valid_q[LEVELS-1];
  assign out_bit_o   = tree_q[0];
  assign out_op_o    = op_q[LEVELS-1];
  assign sticky_o    = sticky_q;

  assign stall      = out_valid_o & ~out_ready_i;
  assign in_ready_o = rst_n & ~stall;
  assign accept     = in_valid_i & in_ready_o;
  assign transfer   = out_valid_o & out_ready_i;

  // Idle inputs are forced to a known word so X never enters the tree.
  assign eff_op = in_valid_i ? in_op_i : OpOr;

  always_comb begin
    leaf = {PAD{eff_op == OpAnd}};
    if (in_valid_i) begin
      leaf[WIDTH-1:0] = in_data_i;
    end
  end

  if (LEVELS == 1) begin : g_root_single
    assign root_op = eff_op;
  end else begin : g_root_multi
    assign root_op = op_q[LEVELS-2];
  end

  always_comb begin
    tree_d = tree_q;
    for (int i = PAD / 2 - 1; i < PAD - 1; i++) begin
      tree_d[i] = combine(eff_op, leaf[2 * i + 2 - PAD], leaf[2 * i + 3 - PAD]);
    end
    // Upper levels take the op that travelled with their source stage.
    for (int i = 0; i < PAD / 2 - 1; i++) begin
      tree_d[i] = combine(op_q[LEVELS - 1 - $clog2(i + 2)], tree_q[2 * i + 1], tree_q[2 * i + 2]);
    end
    if (root_op == 2'b11) begin
      tree_d[0] = ~tree_d[0];
    end
  end

  always_comb begin
    valid_d[0] = accept;
    op_d[0]    = eff_op;
    for (int s = 1; s < LEVELS; s++) begin
      valid_d[s] = valid_q[s-1];
      op_d[s]    = op_q[s-1];
    end
  end

  // Set wins over clear: it reflects the newer result.
  assign sticky_d = (sticky_clr_i ? 1'b0 : sticky_q) | (transfer & out_bit_o);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      tree_q   <= '0;
      op_q     <= '{default: 2'b00};
      sticky_q <= 1'b0;
    end else begin
      if (!stall) begin
        valid_q <= valid_d;
        tree_q  <= tree_d;
        op_q    <= op_d;
      end
      sticky_q <= sticky_d;
    end
  end

endmodule

// File: tb/tb_or_reduce_pipe.sv
// Scoreboard bench for or_reduce_pipe: a WIDTH=16 and a WIDTH=5 instance with directed vectors.
module tb_or_reduce_pipe;

  localparam logic [1:0] OR_ = 2'b00, AND_ = 2'b01, XOR_ = 2'b10, NOR_ = 2'b11;

  typedef struct {
    logic       b;
    logic [1:0] op;
    int         acc;
    bit         lat;
  } exp_t;

  logic clk, rst_n;
  logic in_valid16, in_ready16, out_valid16, out_ready16, out_bit16, clr16, sticky16;
  logic [15:0] in_data16;
  logic [1:0]  in_op16, out_op16;
  logic in_valid5, in_ready5, out_valid5, out_ready5, out_bit5, clr5, sticky5;
  logic [4:0] in_data5;
  logic [1:0] in_op5, out_op5;

  logic exp16, exp5;
  bit   lat16, lat5;
  exp_t q16[$], q5[$];
  exp_t e;
  int   ncyc = 0;
  int   n_chk = 0, n_pass = 0;

  or_reduce_pipe #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid16), .in_ready_o(in_ready16),
    .in_data_i(in_data16), .in_op_i(in_op16), .out_valid_o(out_valid16),
    .out_ready_i(out_ready16), .out_bit_o(out_bit16), .out_op_o(out_op16),
    .sticky_clr_i(clr16), .sticky_o(sticky16)
  );

  or_reduce_pipe #(.WIDTH(5)) u5 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid5), .in_ready_o(in_ready5),
    .in_data_i(in_data5), .in_op_i(in_op5), .out_valid_o(out_valid5),
    .out_ready_i(out_ready5), .out_bit_o(out_bit5), .out_op_o(out_op5),
    .sticky_clr_i(clr5), .sticky_o(sticky5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Scoreboard: push on acceptance, pop and compare on every output transfer.
  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst_n && in_valid16 && in_ready16)
        q16.push_back('{b: exp16, op: in_op16, acc: ncyc, lat: lat16});
      if (rst_n && in_valid5 && in_ready5)
        q5.push_back('{b: exp5, op: in_op5, acc: ncyc, lat: lat5});
      if (out_valid16 && out_ready16) begin
        if (q16.size() == 0) begin
          n_chk++;
          $display("FAIL extra16: unexpected result out_bit=%0d out_op=%0d", out_bit16, out_op16);
        end else begin
          e = q16.pop_front();
          chk("bit16", {31'd0, out_bit16}, {31'd0, e.b});
          chk("op16", {30'd0, out_op16}, {30'd0, e.op});
          if (e.lat) chk("lat16", ncyc - e.acc, 4);
        end
      end
      if (out_valid5 && out_ready5) begin
        if (q5.size() == 0) begin
          n_chk++;
          $display("FAIL extra5: unexpected result out_bit=%0d out_op=%0d", out_bit5, out_op5);
        end else begin
          e = q5.pop_front();
          chk("bit5", {31'd0, out_bit5}, {31'd0, e.b});
          chk("op5", {30'd0, out_op5}, {30'd0, e.op});
          if (e.lat) chk("lat5", ncyc - e.acc, 3);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge, inputs still driven.
  task automatic send(input int sel, input logic [15:0] d, input logic [1:0] op, input logic x,
                      input bit lat);
    bit ok = 1'b0;
    if (sel == 0) begin
      in_valid16 = 1'b1; in_data16 = d; in_op16 = op; exp16 = x; lat16 = lat;
    end else begin
      in_valid5 = 1'b1; in_data5 = d[4:0]; in_op5 = op; exp5 = x; lat5 = lat;
    end
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      ok = (sel == 0) ? in_ready16 : in_ready5;
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL accept_timeout: sel=%0d word %0h never accepted, required acceptance", sel, d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic stop(input int sel);
    if (sel == 0) in_valid16 = 1'b0;
    else in_valid5 = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      #1;
      done = (q16.size() == 0) && (q5.size() == 0) && !out_valid16 && !out_valid5;
    end
    if (!done) begin
      n_chk++;
      $display("FAIL drain: outstanding q16=%0d q5=%0d, required 0", q16.size(), q5.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0;
    in_valid16 = 0; in_data16 = 'x; in_op16 = 0; out_ready16 = 1; clr16 = 0;
    in_valid5 = 0; in_data5 = 'x; in_op5 = 0; out_ready5 = 1; clr5 = 0;
    exp16 = 0; exp5 = 0; lat16 = 0; lat5 = 0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid16}, 0);
    chk("rst_out_bit", {31'd0, out_bit16}, 0);
    chk("rst_out_op", {30'd0, out_op16}, 0);
    chk("rst_sticky", {31'd0, sticky16}, 0);
    chk("rst_in_ready", {31'd0, in_ready16}, 0);
    chk("rst_out_valid5", {31'd0, out_valid5}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic OR
    send(0, 16'h0000, OR_, 1'b0, 1'b1);
    send(0, 16'h0400, OR_, 1'b1, 1'b1);
    stop(0);
    drain();
    chk("sticky_basic", {31'd0, sticky16}, 1);

    // All operators back-to-back
    send(0, 16'hFFFF, AND_, 1'b1, 1'b1);
    send(0, 16'hFFFE, AND_, 1'b0, 1'b1);
    send(0, 16'h0007, XOR_, 1'b1, 1'b1);
    send(0, 16'h0000, NOR_, 1'b1, 1'b1);
    stop(0);
    drain();

    // Non-power-of-2 width
    send(1, 16'h001F, AND_, 1'b1, 1'b1);
    send(1, 16'h0010, OR_, 1'b1, 1'b1);
    send(1, 16'h0015, XOR_, 1'b1, 1'b1);
    send(1, 16'h000F, AND_, 1'b0, 1'b1);
    send(1, 16'h0000, NOR_, 1'b1, 1'b1);
    stop(1);
    drain();

    // Backpressure: 3-cycle stall once the first result appears
    out_ready16 = 1'b0;
    fork
      begin
        send(0, 16'h8000, OR_, 1'b1, 1'b0);
        send(0, 16'h0000, AND_, 1'b0, 1'b0);
        send(0, 16'h0003, XOR_, 1'b0, 1'b0);
        send(0, 16'h0001, NOR_, 1'b0, 1'b0);
        send(0, 16'hF0F0, XOR_, 1'b0, 1'b0);
        send(0, 16'h0100, XOR_, 1'b1, 1'b0);
        stop(0);
      end
      begin
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
          @(negedge clk);
          #1;
          seen = out_valid16;
        end
        if (!seen) begin
          n_chk++;
          $display("FAIL stall_wait: out_valid never rose, required 1");
        end
        for (int k = 0; k < 3; k++) begin
          if (k > 0) begin
            @(negedge clk);
            #1;
          end
          chk("stall_in_ready", {31'd0, in_ready16}, 0);
          chk("stall_bit", {31'd0, out_bit16}, {31'd0, q16[0].b});
          chk("stall_op", {30'd0, out_op16}, {30'd0, q16[0].op});
        end
        @(posedge clk);
        #1;
        out_ready16 = 1'b1;
      end
    join
    drain();

    // Sticky: clear alone, then clear coinciding with a 1 transfer
    clr16 = 1'b1;
    @(posedge clk);
    #1;
    chk("sticky_clr", {31'd0, sticky16}, 0);
    clr16 = 1'b0;
    send(0, 16'hFFFF, OR_, 1'b1, 1'b1);
    stop(0);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      #1;
      seen = out_valid16;
    end
    if (!seen) begin
      n_chk++;
      $display("FAIL sticky_wait: out_valid never rose, required 1");
    end
    clr16 = 1'b1;
    @(posedge clk);
    #1;
    chk("sticky_clr_set", {31'd0, sticky16}, 1);
    @(posedge clk);
    #1;
    chk("sticky_clr_only", {31'd0, sticky16}, 0);
    clr16 = 1'b0;

    // Asynchronous reset with 3 words in flight
    send(0, 16'h0001, OR_, 1'b1, 1'b1);
    stop(0);
    drain();
    out_ready16 = 1'b0;
    send(0, 16'hFFFF, OR_, 1'b1, 1'b0);
    send(0, 16'h0000, OR_, 1'b0, 1'b0);
    send(0, 16'h0001, XOR_, 1'b1, 1'b0);
    stop(0);
    @(posedge clk);
    #1;
    chk("pre_rst_out_valid", {31'd0, out_valid16}, 1);
    chk("pre_rst_sticky", {31'd0, sticky16}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", {31'd0, out_valid16}, 0);
    chk("async_sticky", {31'd0, sticky16}, 0);
    chk("async_in_ready", {31'd0, in_ready16}, 0);
    q16.delete();
    out_ready16 = 1'b1;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (8) @(posedge clk);
    #1;
    chk("no_stale", {31'd0, out_valid16}, 0);
    send(0, 16'h0020, OR_, 1'b1, 1'b1);
    stop(0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
